// File: rtl/data_memory_arbiter_if.sv
// Handshake and memory-pin bundle for data_memory_arbiter.
// slave = arbiter side, master = the two requesters, mem = the data memory.
interface data_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  err0;
    logic                  err1;
    logic                  mem_write;
    logic                  mem_read;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, err0, err1,
               mem_write, mem_read, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1, err0, err1, busy
    );

    modport mem (
        input  mem_write, mem_read, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port data memory.
// Optional address bounds check: define DMEM_ARB_BOUNDS_CHECK_EN.
module data_memory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    data_memory_arbiter_if.slave bus
);
    // state  | meaning
    // IDLE   | wait for a request; arbitrate and latch the winner's request
    // ACCESS | drive the memory pins from the latched request for one cycle
    // DONE   | one-cycle ack (and err) to the granted port
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    if (MEM_AW < 1 || MEM_AW >= ADDR_WIDTH) begin : g_bad_geometry
        $error("data_memory_arbiter: MEM_AW must be in 1..ADDR_WIDTH-1");
    end

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last;
    logic                  r_port;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_ack0;
    logic                  r_ack1;
    logic                  r_err;
    logic                  w_any_req;
    logic                  w_win_port;
    logic                  w_oob;
    logic                  w_mem_write;
    logic                  w_mem_read;
    logic                  w_busy;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    assign w_oob = |r_addr[ADDR_WIDTH-1:MEM_AW];
`else
    assign w_oob = 1'b0;
`endif

    // A tie goes to the port that did not win last time; a lone request always wins.
    always_comb begin
        w_any_req  = bus.req0 | bus.req1;
        w_win_port = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_win_port = ~r_last;
        end else begin
            w_win_port = bus.req1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_next_state = ST_ACCESS;
            ST_ACCESS: w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_port  <= w_win_port;
                        r_last  <= w_win_port;
                        r_we    <= w_win_port ? bus.we1    : bus.we0;
                        r_addr  <= w_win_port ? bus.addr1  : bus.addr0;
                        r_wdata <= w_win_port ? bus.wdata1 : bus.wdata0;
                    end
                end
                ST_ACCESS: begin
                    // Writes and rejected accesses return zero data.
                    r_rdata <= (r_we || w_oob) ? '0 : bus.mem_rdata;
                    r_err   <= w_oob;
                    r_ack0  <= ~r_port;
                    r_ack1  <= r_port;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from r_state so a reset during ACCESS kills them at once.
    always_comb begin
        w_mem_write = 1'b0;
        w_mem_read  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                w_mem_write = r_we & ~w_oob;
                w_mem_read  = ~r_we & ~w_oob;
                w_busy      = 1'b1;
            end
            ST_DONE:   w_busy = 1'b1;
            default:   ;
        endcase
    end

    assign bus.mem_write = w_mem_write;
    assign bus.mem_read  = w_mem_read;
    assign bus.busy      = w_busy;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.err0      = r_ack0 & r_err;
    assign bus.err1      = r_ack1 & r_err;
    assign bus.rdata0    = r_rdata;
    assign bus.rdata1    = r_rdata;
endmodule
